// File: rtl/timer_responder_if.sv
// Bus between the CPU memory stage and the countdown timer, plus the
// interrupt request the timer raises toward CP0.
interface timer_responder_if;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;
  logic        irq;

  modport master (
    output addr, we, byteen, wdata,
    input  rdata, hit, irq
  );

  modport slave (
    input  addr, we, byteen, wdata,
    output rdata, hit, irq
  );
endinterface

// File: rtl/timer_responder.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT in a 16-byte window,
// one-shot or auto-reload operation, level interrupt gated by CTRL.IM.
module timer_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input logic               clk,
  input logic               reset,
  timer_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic        hit;
  logic [1:0]  sel;
  logic        wr_en;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        en;
  logic [1:0]  mode;
  logic        im;
  logic        reload_mode;
  logic [31:0] ctrl_merged;

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  assign hit         = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign sel         = bus.addr[3:2];
  assign wr_en       = bus.we & hit & (|bus.byteen);
  assign wr_ctrl     = wr_en & (sel == 2'd0);
  assign wr_preset   = wr_en & (sel == 2'd1);
  assign en          = ctrl_q[0];
  assign mode        = ctrl_q[2:1];
  assign im          = ctrl_q[3];
  assign reload_mode = (mode == 2'b01);
  assign ctrl_merged = merge({28'b0, ctrl_q}, bus.wdata, bus.byteen);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (en) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_CNT;
      ST_CNT: begin
        if (!en)                   state_d = ST_IDLE;
        else if (count_q <= 32'd1) state_d = ST_INT;
      end
      ST_INT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    unique case (state_q)
      ST_LOAD: count_d = preset_q;
      ST_CNT: begin
        if (en) begin
          if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
          end else begin
            count_d    = '0;
            irq_flag_d = 1'b1;
          end
        end
      end
      ST_INT: begin
        if (reload_mode) irq_flag_d = 1'b0;
        else             ctrl_d[0]  = 1'b0;
      end
      default: ;
    endcase

    // CPU writes are applied last so they override the FSM's EN clear and flag set.
    if (wr_ctrl) begin
      ctrl_d     = ctrl_merged[3:0];
      irq_flag_d = 1'b0;
    end
    if (wr_preset) preset_d = merge(preset_q, bus.wdata, bus.byteen);
  end

  always_comb begin
    bus.hit   = hit;
    bus.irq   = im & irq_flag_q;
    bus.rdata = '0;
    if (hit) begin
      unique case (sel)
        2'd0:    bus.rdata = {28'b0, ctrl_q};
        2'd1:    bus.rdata = preset_q;
        2'd2:    bus.rdata = count_q;
        default: bus.rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_responder.sv
// Self-checking bench for timer_responder: expectations are queued when the
// stimulus is applied and popped when the corresponding output is sampled.
module tb_timer_responder;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic reset;
  timer_responder_if bus();

  exp_t        sb[$];
  int unsigned total;
  int unsigned bad;

  timer_responder #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic expect_v(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: got %h want queued expectation", got);
    end else begin
      e = sb.pop_front();
      check_eq(e.tag, got, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [31:0] off, input logic [31:0] exp);
    expect_v(tag, exp);
    bus.we   = 1'b0;
    bus.addr = BASE + off;
    #1;
    pop_check(bus.rdata);
  endtask

  task automatic irq_chk(input string tag, input logic exp);
    expect_v(tag, {31'b0, exp});
    #1;
    pop_check({31'b0, bus.irq});
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] data, input logic [3:0] be);
    bus.addr   = BASE + off;
    bus.wdata  = data;
    bus.byteen = be;
    bus.we     = 1'b1;
    tick();
    bus.we     = 1'b0;
    bus.byteen = 4'h0;
  endtask

  initial begin
    logic found;
    total      = 0;
    bad        = 0;
    reset      = 1'b0;
    bus.addr   = BASE;
    bus.we     = 1'b1;
    bus.byteen = 4'hF;
    bus.wdata  = 32'hFFFF_FFFF;

    // reset held two edges while a write is attempted
    tick();
    tick();
    reset  = 1'b1;
    bus.we = 1'b0;
    bus.byteen = 4'h0;
    rd("rst_ctrl", 32'h0, 32'h0);
    rd("rst_preset", 32'h4, 32'h0);
    rd("rst_count", 32'h8, 32'h0);
    irq_chk("rst_irq", 1'b0);

    // window decode
    bus.addr = BASE + 32'h8;
    expect_v("hit_in", 32'h1);
    #1 pop_check({31'b0, bus.hit});
    bus.addr = BASE + 32'h10;
    expect_v("hit_out", 32'h0);
    #1 pop_check({31'b0, bus.hit});
    rd("rdata_out", 32'h10, 32'h0);

    // byte merge, read-only COUNT, reserved slot
    wr(32'h4, 32'h1122_3344, 4'hF);
    rd("preset_full", 32'h4, 32'h1122_3344);
    wr(32'h4, 32'hAABB_CCDD, 4'b0100);
    rd("preset_merge", 32'h4, 32'h11BB_3344);
    wr(32'h8, 32'hDEAD_BEEF, 4'hF);
    rd("count_ro", 32'h8, 32'h0);
    wr(32'hC, 32'hDEAD_BEEF, 4'hF);
    rd("reserved", 32'hC, 32'h0);
    wr(32'h0, 32'hFFFF_FFF0, 4'hF);
    rd("ctrl_upper", 32'h0, 32'h0);

    // one-shot, PRESET=5
    wr(32'h4, 32'd5, 4'hF);
    wr(32'h0, 32'h9, 4'hF);
    tick();
    for (int k = 5; k >= 0; k--) begin
      tick();
      rd($sformatf("os_count%0d", k), 32'h8, k);
    end
    irq_chk("os_irq_set", 1'b1);
    tick();
    rd("os_ctrl_en_clr", 32'h0, 32'h8);
    irq_chk("os_irq_hold1", 1'b1);
    tick();
    tick();
    irq_chk("os_irq_hold2", 1'b1);
    wr(32'h0, 32'h8, 4'hF);
    irq_chk("os_irq_clr", 1'b0);

    // auto-reload, PRESET=3, IM=1: pulse on cycles 5, 11, 17 after the write
    wr(32'h4, 32'd3, 4'hF);
    wr(32'h0, 32'hB, 4'hF);
    for (int k = 1; k <= 20; k++) begin
      tick();
      irq_chk($sformatf("ar_irq_c%0d", k), (k >= 5) && (((k - 5) % 6) == 0));
    end
    wr(32'h0, 32'h0, 4'hF);
    tick(); tick(); tick();

    // auto-reload with IM=0
    wr(32'h0, 32'h3, 4'hF);
    for (int k = 1; k <= 14; k++) begin
      tick();
      irq_chk($sformatf("ar_noim_c%0d", k), 1'b0);
    end
    wr(32'h0, 32'h0, 4'hF);
    tick(); tick(); tick();

    // stop mid-count at 6, then re-enable reloads PRESET
    wr(32'h4, 32'd10, 4'hF);
    wr(32'h0, 32'h9, 4'hF);
    tick();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      bus.addr = BASE + 32'h8;
      #1;
      if (bus.rdata == 32'd7) found = 1'b1;
    end
    check_eq("stop_find7", {31'b0, found}, 32'h1);
    wr(32'h0, 32'h8, 4'hF);
    rd("stop_count_a", 32'h8, 32'd6);
    tick();
    rd("stop_count_b", 32'h8, 32'd6);
    tick(); tick();
    rd("stop_count_c", 32'h8, 32'd6);
    irq_chk("stop_irq", 1'b0);
    wr(32'h0, 32'h9, 4'hF);
    tick();
    rd("restart_hold", 32'h8, 32'd6);
    tick();
    rd("restart_load", 32'h8, 32'd10);
    wr(32'h0, 32'h0, 4'hF);
    tick(); tick(); tick();

    // PRESET=0: irq three edges after the CTRL write edge
    wr(32'h4, 32'd0, 4'hF);
    wr(32'h0, 32'h9, 4'hF);
    tick();
    irq_chk("p0_irq_c1", 1'b0);
    tick();
    irq_chk("p0_irq_c2", 1'b0);
    tick();
    irq_chk("p0_irq_c3", 1'b1);

    // CTRL write on the INT edge keeps EN and clears the flag
    wr(32'h0, 32'h9, 4'hF);
    rd("prio_ctrl", 32'h0, 32'h9);
    irq_chk("prio_irq_clr", 1'b0);
    tick();
    irq_chk("prio_load", 1'b0);
    tick();
    irq_chk("prio_cnt", 1'b0);
    tick();
    irq_chk("prio_reexpire", 1'b1);
    wr(32'h0, 32'h0, 4'hF);
    tick(); tick();

    // full-width PRESET
    wr(32'h4, 32'hFFFF_FFFF, 4'hF);
    wr(32'h0, 32'h1, 4'hF);
    tick();
    tick();
    rd("max_load", 32'h8, 32'hFFFF_FFFF);
    tick();
    rd("max_dec", 32'h8, 32'hFFFF_FFFE);
    wr(32'h0, 32'h0, 4'hF);
    tick(); tick();

    // reset during CNT, with a write on the same edge
    wr(32'h4, 32'd10, 4'hF);
    wr(32'h0, 32'h9, 4'hF);
    tick(); tick(); tick(); tick();
    rd("rc_running", 32'h8, 32'd8);
    reset      = 1'b0;
    bus.addr   = BASE;
    bus.wdata  = 32'hFFFF_FFFF;
    bus.byteen = 4'hF;
    bus.we     = 1'b1;
    tick();
    reset      = 1'b1;
    bus.we     = 1'b0;
    bus.byteen = 4'h0;
    rd("rc_ctrl", 32'h0, 32'h0);
    rd("rc_preset", 32'h4, 32'h0);
    rd("rc_count", 32'h8, 32'h0);
    irq_chk("rc_irq", 1'b0);
    tick(); tick(); tick();
    rd("rc_idle_count", 32'h8, 32'h0);

    check_eq("sb_drained", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_responder.md
Name: timer_responder

Overview:
- Memory-mapped countdown timer that acts as the bus-side responder to the CPU's store/load interface.
- Accepts word-aligned accesses with the per-byte write enable mask the CPU computes for sw/sh/sb, and returns read data for lw.
- Raises an interrupt request toward CP0, which is the external interrupt source for the P7 exception path.

Parameters:
- BASE_ADDR, 32'h0000_7F00, base of the 16-byte register window; only BASE_ADDR[31:4] is compared.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; the block resets when reset==0 at a rising clk edge.
- addr  input  32  byte address from the CPU memory stage; bits [1:0] are ignored.
- we  input  1  write strobe; effective only when addr hits the window.
- byteen  input  4  per-byte write enable, bit i covers wdata[8i+7:8i]; 4'b0000 means no write.
- wdata  input  32  store data, already lane-aligned.
- rdata  output  32  combinational read data for the current addr.
- hit  output  1  asserted when addr[31:4]==BASE_ADDR[31:4].
- irq  output  1  interrupt request, equal to CTRL.IM & irq_flag.

Behaviour:
- Registers, selected by offset addr[3:2]:
  - 0: CTRL, read/write. Bit 0 EN, bits [2:1] MODE, bit 3 IM; bits [31:4] read as 0 and ignore writes.
  - 1: PRESET, read/write.
  - 2: COUNT, read-only; writes are ignored.
  - 3: reserved; reads 0, writes ignored.
- Write: a register updates when we & hit & byteen != 0. The new value is a byte-wise merge: enabled lanes take wdata, the other lanes keep the old value.
- Read: rdata = selected register when hit, else 32'h0. Zero latency.
- Reset (reset==0 at a clk edge): CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE. Therefore irq=0 and rdata=0 for any hit address.
- FSM, 2-bit state, advancing one step per clk:
  - IDLE: if EN go to LOAD, else stay.
  - LOAD: COUNT<=PRESET; go to CNT.
  - CNT: if !EN go to IDLE and hold COUNT. Else if COUNT>1, COUNT<=COUNT-1. Else (COUNT==1 or COUNT==0) COUNT<=0, irq_flag<=1, go to INT.
  - INT, MODE 2'b00 (one-shot): EN<=0, go to IDLE. irq_flag stays 1 until any CPU write to CTRL.
  - INT, MODE 2'b01 (auto-reload): irq_flag<=0, go to IDLE. EN stays 1, so the timer reloads via LOAD. irq is high exactly one cycle, during INT.
  - MODE 2'b10 and 2'b11 behave as 2'b00.
- Period (EN=1, starting from IDLE, PRESET=N≥1):
  - Enters INT N+2 cycles after leaving IDLE.
  - Mode 1 repeats every N+3 cycles.
- PRESET=0: treated as immediate expiry; INT is reached 3 cycles after IDLE sees EN.
- Priority: a CPU write to CTRL in the same cycle as the FSM's INT-state EN clear wins, i.e. the written EN value is kept. Any CTRL write clears irq_flag.
- Writing PRESET during CNT does not affect the running COUNT; it takes effect at the next LOAD.
- Clearing EN mid-count: the FSM returns to IDLE on the next edge and COUNT freezes at its current value.
- Reset asserted mid-count or in INT returns everything to reset values on that edge, regardless of we.
- COUNT arithmetic is 32-bit unsigned. PRESET=32'hFFFF_FFFF must count correctly; no wrap below 0 is possible.

Test Plan:
- Reset: reset=0 for 2 cycles with we=1, byteen=4'hF, addr=BASE+0 -> after release, rdata at BASE+0/4/8 = 0 and irq=0.
- Byte merge: write PRESET=32'h1122_3344 with byteen=F, then wdata=32'hAABB_CCDD with byteen=4'b0100 -> PRESET reads 32'h11BB_3344. A write to COUNT leaves it unchanged.
- One-shot: PRESET=5, CTRL=4'b1001 -> COUNT reads 5,4,3,2,1,0, then irq=1 held and CTRL reads 4'b1000. A CTRL write of 4'b1000 -> irq=0 on the next cycle.
- Auto-reload: PRESET=3, CTRL=4'b1011 -> irq pulses one cycle, repeating every 6 cycles, for at least 3 periods. With IM=0 the same sequence gives irq=0 throughout.
- Stop mid-count: PRESET=10, enable, write CTRL.EN=0 when COUNT=6 -> COUNT holds 6 and no irq; re-enable -> COUNT reloads 10.
- Edge cases:
  - PRESET=0 enable -> irq 3 cycles after the CTRL write edge.
  - A CTRL write coinciding with INT in mode 0 keeps the written EN value.
  - Reset during CNT -> COUNT=0, state IDLE.
  - addr=BASE+32'h10 -> hit=0 and rdata=0.
